m_issue_ctrl: RTL
=================

// Module: m_issue_ctrl
// PURPOSE
//  Issue/writeback sequencer that sits directly in front of the M-extension
//  arithmetic unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  - Accepts one M-op from execute and holds its operands stable for the unit's
//    pipeline latency.
//  - Stalls the core while the op is in flight.
//  - Applies the RISC-V divide corner cases.
//  - Emits a single-cycle tagged writeback.
// PARAMETERS
//  XLEN     32  operand/result width
//  RA_W     5   register address width
//  MUL_LAT  2   cycles operands must be held for funct3[2]==0 (multiply)
//  DIV_LAT  2   cycles operands must be held for funct3[2]==1 (divide/rem)
// PORTS
//  clk        in   1      core clock
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      sync kill of the in-flight op (branch/trap)
//  req_valid  in   1      M-op present from execute
//  req_ready  out  1      op accepted this cycle when req_valid&req_ready
//  req_op     in   3      funct3 encoding (MUL=000 .. REMU=111)
//  req_a      in   XLEN   rs1 value
//  req_b      in   XLEN   rs2 value
//  req_rd     in   RA_W   destination register
//  m_en       out  1      one-cycle launch strobe to the M unit
//  m_op       out  3      held opcode to the M unit
//  m_a        out  XLEN   held operand A to the M unit
//  m_b        out  XLEN   held operand B to the M unit
//  m_c        in   XLEN   M unit result
//  stall      out  1      freeze upstream pipeline
//  busy       out  1      state != IDLE
//  wb_valid   out  1      writeback strobe, one cycle
//  wb_rd      out  RA_W   writeback destination
//  wb_data    out  XLEN   writeback value
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
//  - Reset: state=IDLE, cnt=0, all op/operand/wb registers 0, outputs 0 except
//    req_ready=1.
//  - FSM:
//    - IDLE -> BUSY on accept.
//    - BUSY -> DONE when cnt==LAT-1.
//    - DONE -> IDLE unconditionally.
//    - Any state -> IDLE on flush.
//  - req_ready = (state==IDLE) & ~flush.
//  - Accept latches op, a, b, rd, and LAT = (op[2] ? DIV_LAT : MUL_LAT); cnt<=0.
//  - m_op, m_a, m_b are driven from the latched registers and stay constant for
//    all BUSY cycles.
//  - m_en=1 only in the first BUSY cycle.
//  - In the last BUSY cycle, wb_data <= fixup(m_c) and wb_rd <= rd (registered).
//  - wb_valid = (state==DONE) & ~flush & (wb_rd!=0). An x0 destination
//    completes silently.
//  - Latency: accept at edge N -> wb_valid high in cycle N+LAT+1 (MUL default:
//    3 cycles). No new accept before DONE; throughput is 1 op per LAT+2 cycles.
//  - stall = (state==IDLE & req_valid) | (state==BUSY). Deasserted in DONE so
//    the instruction retires with its writeback.
//  - Fixup (op[2]==1 only; MUL ops pass m_c unchanged):
//    - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//    - DIV a==0x80000000, b==0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//    - Otherwise m_c.
//  - Fixup decisions use the latched a/b, never live req_*.
//  - flush in IDLE blocks accept. In BUSY it drops the op; the M unit result is
//    discarded. In DONE it suppresses wb_valid. In all cases state is IDLE next
//    cycle.
//  - flush and req_valid in the same cycle: flush wins, no accept.
//  - Reset mid-op: immediate IDLE; no writeback afterwards.
//  - cnt is wide enough for max(MUL_LAT,DIV_LAT). LAT>=1 is required.
// STRUCTURE
//  - m_pkg holds funct3 localparams (MUL..REMU), FSM state encoding, and
//    INT_MIN / ALL_ONES constants. Shared with the M unit and decode.
//  - Sub-module m_result_fixup: combinational corner-case mux
//    (op, a, b, m_c -> result).
//  - FSM, counter and operand/wb registers stay in this module.
// TESTING
//  1. MUL a=7, b=0xFFFFFFFD, rd=5 -> m_en one cycle; wb_valid at accept+3;
//     wb_rd=5; wb_data=0xFFFFFFEB.
//  2. DIV a=0x80000000, b=0xFFFFFFFF -> wb_data=0x80000000.
//     REM same operands -> wb_data=0.
//  3. DIVU a=100, b=0 -> 0xFFFFFFFF; REMU a=100, b=0 -> 0x00000064.
//  4. req_valid held with MUL then DIVU 9/2 -> req_ready low and stall high
//     through BUSY. Second op accepted only in the IDLE after DONE.
//     Results 0x...,4 in order. m_a/m_b stable throughout BUSY.
//  5. flush in the 2nd BUSY cycle -> no wb_valid, req_ready=1 next cycle.
//     rst_n low mid-BUSY -> all outputs 0, req_ready=1.
//  6. MULHU 0xFFFFFFFF*0xFFFFFFFF, rd=0 -> no wb_valid; stall released after
//     accept+2.

Source files
------------

// File: rtl/m_pkg.sv
// -----------------------------------------------------------------------------
// m_pkg
//   Shared definitions for the M-extension datapath: operand widths, funct3
//   opcodes, issue FSM state encoding and the divide corner-case constants.
//   Imported by the issue sequencer, the result fixup mux, the M unit and
//   decode.
// -----------------------------------------------------------------------------
package m_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    // funct3 encodings of the M extension
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // funct3[2] separates divide/remainder from the multiply family
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/m_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// m_issue_ctrl_if
//   Request channel from execute into the M-op issue sequencer.
//   req_valid / req_ready : valid/ready handshake, op accepted when both high
//   req_op                : funct3 of the M-op
//   req_a / req_b         : rs1 / rs2 values
//   req_rd                : destination register
//   master = execute side, slave = issue sequencer side.
// -----------------------------------------------------------------------------
interface m_issue_ctrl_if;
    import m_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [RA_W-1:0] req_rd;

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd,
        output req_ready
    );

endinterface

// File: rtl/m_result_fixup.sv
// -----------------------------------------------------------------------------
// m_result_fixup
//   Combinational mux applying the RISC-V divide corner cases to the raw
//   M unit result. Multiply ops pass through unchanged.
//   i_op     : funct3 of the op
//   i_a/i_b  : operands the op was launched with
//   i_m_c    : raw M unit result
//   o_result : architecturally correct result
// -----------------------------------------------------------------------------
module m_result_fixup
    import m_pkg::*;
(
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [XLEN-1:0] i_m_c,
    output logic [XLEN-1:0] o_result
);

    logic w_b_zero;
    logic w_ovf;

    assign w_b_zero = (i_b == '0);
    assign w_ovf    = (i_a == INT_MIN) && (i_b == ALL_ONES);

    always_comb begin
        // NOTE: default first so every path assigns o_result; no latch is inferred.
        o_result = i_m_c;
        unique case (i_op)
            F3_DIV: begin
                if (w_b_zero)   o_result = ALL_ONES;
                else if (w_ovf) o_result = INT_MIN;
            end
            F3_DIVU: begin
                if (w_b_zero)   o_result = ALL_ONES;
            end
            F3_REM: begin
                if (w_b_zero)   o_result = i_a;
                else if (w_ovf) o_result = '0;
            end
            F3_REMU: begin
                if (w_b_zero)   o_result = i_a;
            end
            default: ;  // multiply family: raw product
        endcase
    end

endmodule

// File: rtl/m_issue_ctrl.sv
// -----------------------------------------------------------------------------
// m_issue_ctrl
//   Issue/writeback sequencer in front of the M-extension arithmetic unit.
//   Accepts one op, holds its operands for the unit latency while stalling
//   the core, applies divide corner cases and emits a one-cycle writeback.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_flush      : kills the in-flight op / blocks accept
//   req          : request channel (slave side)
//   o_m_en       : launch strobe, first BUSY cycle only
//   o_m_op/a/b   : latched op and operands to the M unit
//   i_m_c        : M unit result
//   o_stall      : freeze upstream pipeline
//   o_busy       : sequencer not idle
//   o_wb_valid   : one-cycle writeback strobe (suppressed for x0)
//   o_wb_rd/data : writeback destination and value
// -----------------------------------------------------------------------------
module m_issue_ctrl
    import m_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    m_issue_ctrl_if.slave    req,
    output logic             o_m_en,
    output logic [2:0]       o_m_op,
    output logic [XLEN-1:0]  o_m_a,
    output logic [XLEN-1:0]  o_m_b,
    input  logic [XLEN-1:0]  i_m_c,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_wb_valid,
    output logic [RA_W-1:0]  o_wb_rd,
    output logic [XLEN-1:0]  o_wb_data
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last;     // LAT-1 of the op in flight
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [RA_W-1:0] r_rd;
    logic [RA_W-1:0] r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic            w_accept;
    logic            w_last_busy;
    logic [XLEN-1:0] w_fixed;

    assign w_accept    = req.req_valid & req.req_ready;
    assign w_last_busy = (r_state == ST_BUSY) && (r_cnt == r_last);

    // Fixup works on the latched operands, never on the live request.
    m_result_fixup u_fixup (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_m_c    (i_m_c),
        .o_result (w_fixed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        req.req_ready  = (r_state == ST_IDLE) & ~i_flush;
        o_m_en         = (r_state == ST_BUSY) && (r_cnt == '0);
        o_stall        = ((r_state == ST_IDLE) & req.req_valid) | (r_state == ST_BUSY);
        o_busy         = (r_state != ST_IDLE);
        o_wb_valid     = (r_state == ST_DONE) & ~i_flush & (r_wb_rd != '0);

        unique case (r_state)
            ST_IDLE: if (w_accept)    w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last_busy) w_state_nxt = ST_DONE;
            ST_DONE:                  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase

        if (i_flush) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every datapath register is reset so the M unit and writeback ports read 0 after reset.
            r_cnt     <= '0;
            r_last    <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rd      <= '0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            if (w_accept) begin
                r_cnt  <= '0;
                r_last <= is_div_op(req.req_op) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                r_op   <= req.req_op;
                r_a    <= req.req_a;
                r_b    <= req.req_b;
                r_rd   <= req.req_rd;
            end else if (r_state == ST_BUSY) begin
                r_cnt  <= r_cnt + 1'b1;
            end

            if (w_last_busy && !i_flush) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_fixed;
            end
        end
    end

    assign o_m_op    = r_op;
    assign o_m_a     = r_a;
    assign o_m_b     = r_b;
    assign o_wb_rd   = r_wb_rd;
    assign o_wb_data = r_wb_data;

endmodule
